// File: rtl/rpn_stack_ctl.sv
// LIFO operand stack for the RPN calculator datapath.
// Push/pop/replace/reduce with status and sticky error flags.
module rpn_stack_ctl #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_stb,
  input  logic          push_stb,
  input  logic          pop_stb,
  input  logic          rdc_stb,
  input  logic [DW-1:0] push_dat,
  output logic [DW-1:0] tos_dat,
  output logic [DW-1:0] nos_dat,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ovf_err,
  output logic          udf_err
);

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] TWO  = (AW+1)'(2);
  localparam logic [AW:0] FULC = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] ptr1, ptr2;
  logic          empty_w, full_w;

  assign ptr1    = count_q[AW-1:0] - AW'(1);
  assign ptr2    = count_q[AW-1:0] - AW'(2);
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULC);

  // Next-state decode: one operation per cycle, priority ordered.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    waddr   = '0;
    if (clr_stb) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (rdc_stb) begin
      if (count_q >= TWO) begin
        we      = 1'b1;
        waddr   = ptr2;
        count_d = count_q - ONE;
      end else begin
        udf_d = 1'b1;
      end
    end else if (push_stb && pop_stb) begin
      if (!empty_w) begin
        we    = 1'b1;
        waddr = ptr1;
      end else begin
        udf_d = 1'b1;
      end
    end else if (push_stb) begin
      if (!full_w) begin
        we      = 1'b1;
        waddr   = count_q[AW-1:0];
        count_d = count_q + ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop_stb) begin
      if (!empty_w) begin
        count_d = count_q - ONE;
      end else begin
        udf_d = 1'b1;
      end
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents are not reset, writes blocked during reset.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem_q[waddr] <= push_dat;
    end
  end

  assign tos_dat = empty_w ? '0 : mem_q[ptr1];
  assign nos_dat = (count_q < TWO) ? '0 : mem_q[ptr2];
  assign count   = count_q;
  assign empty   = empty_w;
  assign full    = full_w;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_rpn_stack_ctl.sv
// Bench for rpn_stack_ctl: directed scenarios plus random ops
// checked against a queue-based stack model.
module tb_rpn_stack_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_stb = 1'b0;
  logic        push_stb = 1'b0;
  logic        pop_stb = 1'b0;
  logic        rdc_stb = 1'b0;
  logic [31:0] push_dat = '0;
  logic [31:0] tos_dat, nos_dat;
  logic [4:0]  count;
  logic        empty, full, ovf_err, udf_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  bit          movf, mudf;

  rpn_stack_ctl #(.DW(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr_stb(clr_stb),
    .push_stb(push_stb), .pop_stb(pop_stb),
    .rdc_stb(rdc_stb), .push_dat(push_dat),
    .tos_dat(tos_dat), .nos_dat(nos_dat),
    .count(count), .empty(empty), .full(full),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [31:0] t;
    if (!rst_n) begin
      mq.delete(); movf = 0; mudf = 0;
    end else if (clr_stb) begin
      mq.delete(); movf = 0; mudf = 0;
    end else if (rdc_stb) begin
      if (mq.size() >= 2) begin
        t = mq.pop_back();
        mq[mq.size()-1] = push_dat;
      end else mudf = 1;
    end else if (push_stb && pop_stb) begin
      if (mq.size() >= 1) mq[mq.size()-1] = push_dat;
      else mudf = 1;
    end else if (push_stb) begin
      if (mq.size() < 16) mq.push_back(push_dat);
      else movf = 1;
    end else if (pop_stb) begin
      if (mq.size() > 0) t = mq.pop_back();
      else mudf = 1;
    end
  endtask

  task automatic op(input bit c, input bit p, input bit o,
                    input bit r, input logic [31:0] d);
    clr_stb = c; push_stb = p; pop_stb = o;
    rdc_stb = r; push_dat = d;
    @(posedge clk);
    model_edge();
    #1;
    clr_stb = 0; push_stb = 0; pop_stb = 0;
    rdc_stb = 0; push_dat = '0;
  endtask

  task automatic push(input logic [31:0] d);
    op(0, 1, 0, 0, d);
  endtask

  task automatic test_reset();
    rst_n = 0;
    op(0, 0, 0, 0, 0);
    op(1, 1, 0, 0, 32'h55);
    rst_n = 1;
    checks++;
    if ({count, empty, full, ovf_err, udf_err} !== {5'd0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_status got %0d/%b%b%b%b exp 0/1000",
               count, empty, full, ovf_err, udf_err);
    end
    checks++;
    if (tos_dat !== 0 || nos_dat !== 0) begin
      errors++;
      $display("FAIL reset_data got tos=%0d nos=%0d exp 0 0", tos_dat, nos_dat);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) push(i);
    checks++;
    if (full !== 1 || count !== 16) begin
      errors++;
      $display("FAIL fill_full got full=%b count=%0d exp 1 16", full, count);
    end
    checks++;
    if (tos_dat !== 16 || nos_dat !== 15) begin
      errors++;
      $display("FAIL fill_data got tos=%0d nos=%0d exp 16 15", tos_dat, nos_dat);
    end
    checks++;
    if (ovf_err !== 0) begin
      errors++;
      $display("FAIL fill_noovf got %b exp 0", ovf_err);
    end
    push(99);
    checks++;
    if (ovf_err !== 1 || tos_dat !== 16 || count !== 16) begin
      errors++;
      $display("FAIL ovf got ovf=%b tos=%0d count=%0d exp 1 16 16",
               ovf_err, tos_dat, count);
    end
    checks++;
    if (nos_dat !== 15 || udf_err !== 0) begin
      errors++;
      $display("FAIL ovf_nos got nos=%0d udf=%b exp 15 0", nos_dat, udf_err);
    end
  endtask

  task automatic test_underflow();
    op(1, 0, 0, 0, 0);
    op(0, 0, 1, 0, 0);
    checks++;
    if (udf_err !== 1 || count !== 0 || empty !== 1) begin
      errors++;
      $display("FAIL udf_pop got udf=%b count=%0d empty=%b exp 1 0 1",
               udf_err, count, empty);
    end
    push(5);
    op(0, 0, 0, 1, 7);
    checks++;
    if (udf_err !== 1 || count !== 1 || tos_dat !== 5) begin
      errors++;
      $display("FAIL udf_rdc got udf=%b count=%0d tos=%0d exp 1 1 5",
               udf_err, count, tos_dat);
    end
    op(1, 0, 0, 0, 0);
    op(0, 1, 1, 0, 4);
    checks++;
    if (udf_err !== 1 || count !== 0 || ovf_err !== 0) begin
      errors++;
      $display("FAIL udf_repl got udf=%b count=%0d ovf=%b exp 1 0 0",
               udf_err, count, ovf_err);
    end
  endtask

  task automatic test_rpn_add();
    op(1, 0, 0, 0, 0);
    push(3);
    push(4);
    checks++;
    if (tos_dat !== 4 || nos_dat !== 3 || count !== 2) begin
      errors++;
      $display("FAIL rpn_push got tos=%0d nos=%0d count=%0d exp 4 3 2",
               tos_dat, nos_dat, count);
    end
    op(0, 0, 0, 1, 7);
    checks++;
    if (tos_dat !== 7 || nos_dat !== 0 || count !== 1) begin
      errors++;
      $display("FAIL rpn_rdc got tos=%0d nos=%0d count=%0d exp 7 0 1",
               tos_dat, nos_dat, count);
    end
    checks++;
    if (udf_err !== 0 || ovf_err !== 0) begin
      errors++;
      $display("FAIL rpn_err got udf=%b ovf=%b exp 0 0", udf_err, ovf_err);
    end
  endtask

  task automatic test_replace_priority();
    op(1, 0, 0, 0, 0);
    push(2);
    push(9);
    op(0, 1, 1, 0, 6);
    checks++;
    if (tos_dat !== 6 || nos_dat !== 2 || count !== 2) begin
      errors++;
      $display("FAIL repl got tos=%0d nos=%0d count=%0d exp 6 2 2",
               tos_dat, nos_dat, count);
    end
    op(0, 1, 1, 1, 1);
    checks++;
    if (tos_dat !== 1 || nos_dat !== 0 || count !== 1) begin
      errors++;
      $display("FAIL rdc_prio got tos=%0d nos=%0d count=%0d exp 1 0 1",
               tos_dat, nos_dat, count);
    end
  endtask

  task automatic test_clear_reset_mid();
    op(1, 0, 0, 0, 0);
    op(0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) push(32'h100 + i);
    for (int i = 0; i < 11; i++) op(0, 0, 1, 0, 0);
    checks++;
    if (count !== 5 || ovf_err !== 1 || udf_err !== 1 || tos_dat !== 32'h104) begin
      errors++;
      $display("FAIL pre_clr got count=%0d ovf=%b udf=%b tos=%h exp 5 1 1 104",
               count, ovf_err, udf_err, tos_dat);
    end
    op(1, 1, 0, 0, 32'hAA);
    checks++;
    if (count !== 0 || ovf_err !== 0 || udf_err !== 0 || tos_dat !== 0) begin
      errors++;
      $display("FAIL clr_push got count=%0d ovf=%b udf=%b tos=%0d exp 0 0 0 0",
               count, ovf_err, udf_err, tos_dat);
    end
    push(8);
    checks++;
    if (count !== 1 || tos_dat !== 8) begin
      errors++;
      $display("FAIL push8 got count=%0d tos=%0d exp 1 8", count, tos_dat);
    end
    rst_n = 0;
    push(3);
    rst_n = 1;
    checks++;
    if (count !== 0 || empty !== 1 || tos_dat !== 0) begin
      errors++;
      $display("FAIL rst_mid got count=%0d empty=%b tos=%0d exp 0 1 0",
               count, empty, tos_dat);
    end
  endtask

  task automatic test_random();
    logic [31:0] et, en;
    int n;
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      op($urandom_range(0, 59) == 0,
         $urandom_range(0, 99) < 55,
         $urandom_range(0, 99) < 35,
         $urandom_range(0, 99) < 12,
         $urandom);
      n  = mq.size();
      et = (n >= 1) ? mq[n-1] : 32'd0;
      en = (n >= 2) ? mq[n-2] : 32'd0;
      checks++;
      if ({tos_dat, nos_dat, count, empty, full, ovf_err, udf_err} !==
          {et, en, 5'(n), n == 0, n == 16, movf, mudf}) begin
        errors++;
        $display("FAIL rand_%0d got tos=%h nos=%h cnt=%0d e=%b f=%b o=%b u=%b exp tos=%h nos=%h cnt=%0d o=%b u=%b",
                 k, tos_dat, nos_dat, count, empty, full, ovf_err, udf_err,
                 et, en, n, movf, mudf);
      end
    end
    rst_n = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_rpn_add();
    test_replace_priority();
    test_clear_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
